// File: rtl/div_arbiter_if.sv
// Bundle of requester, divider and response signals shared by div_arbiter and its environment.
// Latency: none (wires only).
// Backpressure: none; gnt and rsp_valid are single-cycle pulses.
interface div_arbiter_if #(
  parameter int W = 5
);
  // requester 0
  logic         req0;
  logic [W-1:0] a0;
  logic [W-1:0] b0;
  logic         gnt0;
  // requester 1
  logic         req1;
  logic [W-1:0] a1;
  logic [W-1:0] b1;
  logic         gnt1;
  // divider side
  logic         div_load;
  logic [W-1:0] div_a;
  logic [W-1:0] div_b;
  logic [W-1:0] div_q;
  logic [W-1:0] div_r;
  logic         div_err;
  // shared response bus
  logic         rsp_valid;
  logic         rsp_id;
  logic [W-1:0] rsp_q;
  logic [W-1:0] rsp_r;
  logic         rsp_err;
  logic         busy;

  // environment side: requesters plus the divider datapath
  modport master (
    output req0, a0, b0, req1, a1, b1, div_q, div_r, div_err,
    input  gnt0, gnt1, div_load, div_a, div_b,
    input  rsp_valid, rsp_id, rsp_q, rsp_r, rsp_err, busy
  );

  // arbiter side
  modport slave (
    input  req0, a0, b0, req1, a1, b1, div_q, div_r, div_err,
    output gnt0, gnt1, div_load, div_a, div_b,
    output rsp_valid, rsp_id, rsp_q, rsp_r, rsp_err, busy
  );
endinterface

// File: rtl/div_arbiter.sv
// Round-robin sharing of one divider between two requesters; optional DIV_ZERO_BYPASS_EN answers b==0 without the divider.
// Latency: gnt pulse to rsp_valid = LOAD_CYC+DIV_LAT cycles (1 cycle for a bypassed divide-by-zero).
// Backpressure: requesters hold req until gnt; the response pulse must be taken as issued.
module div_arbiter #(
  parameter int W        = 5,
  parameter int LOAD_CYC = 5,
  parameter int DIV_LAT  = 5
) (
  input  logic         clk,
  input  logic         res,
  div_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, RESP} state_t;

  state_t       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         last_id_q, last_id_d;
  logic         byp_q, byp_d;
  logic         gnt0_q, gnt0_d;
  logic         gnt1_q, gnt1_d;
  logic         div_load_q, div_load_d;
  logic [W-1:0] div_a_q, div_a_d;
  logic [W-1:0] div_b_q, div_b_d;
  logic         rsp_valid_q, rsp_valid_d;
  logic         rsp_id_q, rsp_id_d;
  logic [W-1:0] rsp_quo_q, rsp_quo_d;
  logic [W-1:0] rsp_rem_q, rsp_rem_d;
  logic         rsp_err_q, rsp_err_d;

  logic         any_req;
  logic         pick;
  logic [W-1:0] pick_a;
  logic [W-1:0] pick_b;

  // Winner selection: a lone request wins; under contention the requester not served last wins.
  always_comb begin
    any_req = bus.req0 | bus.req1;
    pick    = (bus.req0 & bus.req1) ? ~last_id_q : bus.req1;
    pick_a  = pick ? bus.a1 : bus.a0;
    pick_b  = pick ? bus.b1 : bus.b0;
  end

  // Next-state and output computation. A grant may also be taken from RESP so a waiting
  // requester gets its gnt the cycle right after the previous rsp_valid.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_id_d   = last_id_q;
    byp_d       = byp_q;
    gnt0_d      = 1'b0;
    gnt1_d      = 1'b0;
    div_load_d  = div_load_q;
    div_a_d     = div_a_q;
    div_b_d     = div_b_q;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_quo_d   = rsp_quo_q;
    rsp_rem_d   = rsp_rem_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      IDLE, RESP: begin
        if (any_req) begin
          gnt0_d    = ~pick;
          gnt1_d    = pick;
          div_a_d   = pick_a;
          div_b_d   = pick_b;
          last_id_d = pick;
          cnt_d     = 4'd0;
`ifdef DIV_ZERO_BYPASS_EN
          if (pick_b == '0) begin
            // one WAIT cycle with byp set, divider never loaded
            byp_d      = 1'b1;
            div_load_d = 1'b0;
            state_d    = WAIT;
          end else begin
            byp_d      = 1'b0;
            div_load_d = 1'b1;
            state_d    = LOAD;
          end
`else
          byp_d      = 1'b0;
          div_load_d = 1'b1;
          state_d    = LOAD;
`endif
        end else begin
          state_d = IDLE;
        end
      end

      LOAD: begin
        if (cnt_q == 4'(LOAD_CYC - 1)) begin
          div_load_d = 1'b0;
          cnt_d      = 4'd0;
          state_d    = WAIT;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      WAIT: begin
        if (byp_q || (cnt_q == 4'(DIV_LAT - 1))) begin
          rsp_valid_d = 1'b1;
          rsp_id_d    = last_id_q;
          if (byp_q) begin
            rsp_quo_d = '0;
            rsp_rem_d = '0;
            rsp_err_d = 1'b1;
          end else begin
            rsp_quo_d = bus.div_q;
            rsp_rem_d = bus.div_r;
            rsp_err_d = bus.div_err;
          end
          cnt_d   = 4'd0;
          byp_d   = 1'b0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any job in flight and zeroes every output.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      last_id_q   <= 1'b1;
      byp_q       <= 1'b0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      div_load_q  <= 1'b0;
      div_a_q     <= '0;
      div_b_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_quo_q   <= '0;
      rsp_rem_q   <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_id_q   <= last_id_d;
      byp_q       <= byp_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      div_load_q  <= div_load_d;
      div_a_q     <= div_a_d;
      div_b_q     <= div_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_quo_q   <= rsp_quo_d;
      rsp_rem_q   <= rsp_rem_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.gnt0      = gnt0_q;
  assign bus.gnt1      = gnt1_q;
  assign bus.div_load  = div_load_q;
  assign bus.div_a     = div_a_q;
  assign bus.div_b     = div_b_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_q     = rsp_quo_q;
  assign bus.rsp_r     = rsp_rem_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_div_arbiter.sv
// Directed bench for div_arbiter with a behavioural 5-bit divider on the divider side.
// Latency: checks gnt-to-response distance per job.
// Backpressure: none; responses are captured on their pulse.
module tb_div_arbiter;

  localparam int W = 5;

  logic clk;
  logic res;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   ovl_gnt = 0;
  int   ovl_rsp = 0;

  div_arbiter_if #(.W(W)) ifc ();

  div_arbiter #(.W(W), .LOAD_CYC(5), .DIV_LAT(5)) dut (
    .clk (clk),
    .res (res),
    .bus (ifc.slave)
  );

  // behavioural divider: divide by zero reports err, all-ones quotient, remainder = dividend
  assign ifc.div_q   = (ifc.div_b == '0) ? '1 : ifc.div_a / ifc.div_b;
  assign ifc.div_r   = (ifc.div_b == '0) ? ifc.div_a : ifc.div_a % ifc.div_b;
  assign ifc.div_err = (ifc.div_b == '0);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // exclusivity watchers
  always @(negedge clk) begin
    if (ifc.gnt0 && ifc.gnt1) ovl_gnt <= ovl_gnt + 1;
    if (ifc.rsp_valid && ifc.div_load) ovl_rsp <= ovl_rsp + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_zero(input string nm);
    check({nm, "_gnt0"},      int'(ifc.gnt0), 0);
    check({nm, "_gnt1"},      int'(ifc.gnt1), 0);
    check({nm, "_div_load"},  int'(ifc.div_load), 0);
    check({nm, "_div_a"},     int'(ifc.div_a), 0);
    check({nm, "_div_b"},     int'(ifc.div_b), 0);
    check({nm, "_rsp_valid"}, int'(ifc.rsp_valid), 0);
    check({nm, "_rsp_id"},    int'(ifc.rsp_id), 0);
    check({nm, "_rsp_q"},     int'(ifc.rsp_q), 0);
    check({nm, "_rsp_r"},     int'(ifc.rsp_r), 0);
    check({nm, "_rsp_err"},   int'(ifc.rsp_err), 0);
    check({nm, "_busy"},      int'(ifc.busy), 0);
  endtask

  task automatic wait_rsp(input int lim, output bit got);
    got = 1'b0;
    for (int t = 0; t < lim; t++) begin
      @(negedge clk);
      if (ifc.rsp_valid) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  // One isolated job: request, grant, response, with latency and load-window checks.
  task automatic run_job(input string nm, input bit id, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er, input bit ee,
                         input int elat, input int eload);
    bit got;
    int g;
    int ld;
    int bad;
    if (id) begin ifc.req1 = 1'b1; ifc.a1 = a; ifc.b1 = b; end
    else    begin ifc.req0 = 1'b1; ifc.a0 = a; ifc.b0 = b; end
    got = 1'b0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (id ? ifc.gnt1 : ifc.gnt0) begin
        got = 1'b1;
        break;
      end
    end
    check({nm, "_gnt"}, int'(got), 1);
    ifc.req0 = 1'b0;
    ifc.req1 = 1'b0;
    g   = cyc;
    ld  = 0;
    bad = 0;
    got = 1'b0;
    if (ifc.div_load) begin
      ld++;
      if (ifc.div_a != a || ifc.div_b != b) bad++;
    end
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (ifc.rsp_valid) begin
        got = 1'b1;
        break;
      end
      if (ifc.div_load) begin
        ld++;
        if (ifc.div_a != a || ifc.div_b != b) bad++;
      end
    end
    check({nm, "_rsp_seen"}, int'(got), 1);
    check({nm, "_latency"},  cyc - g, elat);
    check({nm, "_rsp_id"},   int'(ifc.rsp_id), int'(id));
    check({nm, "_rsp_q"},    int'(ifc.rsp_q), int'(eq));
    check({nm, "_rsp_r"},    int'(ifc.rsp_r), int'(er));
    check({nm, "_rsp_err"},  int'(ifc.rsp_err), int'(ee));
    check({nm, "_load_cyc"}, ld, eload);
    check({nm, "_opnd_stable"}, bad, 0);
  endtask

  typedef struct {
    string          nm;
    bit             id;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [W-1:0]   q;
    logic [W-1:0]   r;
    bit             err;
    int             lat;
    int             ld;
  } vec_t;

  vec_t tbl[6];

  initial begin
    bit got;
    int g1;
    int nrsp;
    int rcyc;

    tbl[0] = '{"single0",  1'b0, 5'd29, 5'd14, 5'd2,  5'd1,  1'b0, 10, 5};
    tbl[1] = '{"by_one",   1'b0, 5'd31, 5'd1,  5'd31, 5'd0,  1'b0, 10, 5};
    tbl[2] = '{"small_q",  1'b1, 5'd7,  5'd9,  5'd0,  5'd7,  1'b0, 10, 5};
    tbl[3] = '{"zero_a",   1'b0, 5'd0,  5'd5,  5'd0,  5'd0,  1'b0, 10, 5};
    tbl[4] = '{"single1",  1'b1, 5'd21, 5'd13, 5'd1,  5'd8,  1'b0, 10, 5};
`ifdef DIV_ZERO_BYPASS_EN
    tbl[5] = '{"divzero",  1'b1, 5'd21, 5'd0,  5'd0,  5'd0,  1'b1, 1,  0};
`else
    tbl[5] = '{"divzero",  1'b1, 5'd21, 5'd0,  5'd31, 5'd21, 1'b1, 10, 5};
`endif

    res      = 1'b0;
    ifc.req0 = 1'b0; ifc.a0 = '0; ifc.b0 = '0;
    ifc.req1 = 1'b0; ifc.a1 = '0; ifc.b1 = '0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    res = 1'b1;
    repeat (2) @(negedge clk);

    // contention straight after reset: requester 0 first, requester 1 right behind
    ifc.req0 = 1'b1; ifc.a0 = 5'd10; ifc.b0 = 5'd26;
    ifc.req1 = 1'b1; ifc.a1 = 5'd21; ifc.b1 = 5'd13;
    got = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (ifc.gnt0 || ifc.gnt1) begin
        got = 1'b1;
        break;
      end
    end
    check("cont_first_gnt0", int'(got && ifc.gnt0), 1);
    ifc.req0 = 1'b0;
    wait_rsp(40, got);
    check("cont_rsp0_seen", int'(got), 1);
    check("cont_rsp0_id",   int'(ifc.rsp_id), 0);
    check("cont_rsp0_q",    int'(ifc.rsp_q), 0);
    check("cont_rsp0_r",    int'(ifc.rsp_r), 10);
    @(negedge clk);
    check("cont_gnt1_next", int'(ifc.gnt1), 1);
    ifc.req1 = 1'b0;
    wait_rsp(40, got);
    check("cont_rsp1_seen", int'(got), 1);
    check("cont_rsp1_id",   int'(ifc.rsp_id), 1);
    check("cont_rsp1_q",    int'(ifc.rsp_q), 1);
    check("cont_rsp1_r",    int'(ifc.rsp_r), 8);
    repeat (2) @(negedge clk);

    // isolated jobs from the vector table
    for (int i = 0; i < 6; i++) begin
      run_job(tbl[i].nm, tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r,
              tbl[i].err, tbl[i].lat, tbl[i].ld);
      repeat (2) @(negedge clk);
    end

    // both held for four jobs: strict alternation starting with 0 (last served was 1)
    ifc.req0 = 1'b1; ifc.a0 = 5'd20; ifc.b0 = 5'd3;
    ifc.req1 = 1'b1; ifc.a1 = 5'd17; ifc.b1 = 5'd4;
    for (int k = 0; k < 4; k++) begin
      wait_rsp(40, got);
      check($sformatf("alt%0d_seen", k), int'(got), 1);
      check($sformatf("alt%0d_id", k), int'(ifc.rsp_id), k % 2);
      check($sformatf("alt%0d_q", k), int'(ifc.rsp_q), (k % 2) ? 4 : 6);
      check($sformatf("alt%0d_r", k), int'(ifc.rsp_r), (k % 2) ? 1 : 2);
    end
    ifc.req0 = 1'b0;
    ifc.req1 = 1'b0;
    repeat (3) @(negedge clk);

    // requester 1 pulses for one cycle while busy and withdraws: never served
    ifc.req0 = 1'b1; ifc.a0 = 5'd29; ifc.b0 = 5'd14;
    got = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (ifc.gnt0) begin
        got = 1'b1;
        break;
      end
    end
    check("wd_gnt0", int'(got), 1);
    ifc.req0 = 1'b0;
    g1   = 0;
    nrsp = 0;
    @(negedge clk);
    ifc.req1 = 1'b1; ifc.a1 = 5'd5; ifc.b1 = 5'd1;
    @(negedge clk);
    ifc.req1 = 1'b0;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      if (ifc.gnt1) g1++;
      if (ifc.rsp_valid) begin
        nrsp++;
        check("wd_rsp_id", int'(ifc.rsp_id), 0);
      end
    end
    check("wd_no_gnt1", g1, 0);
    check("wd_one_rsp", nrsp, 1);

    // reset in the third WAIT cycle aborts the job silently
    ifc.req0 = 1'b1; ifc.a0 = 5'd29; ifc.b0 = 5'd3;
    got = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (ifc.gnt0) begin
        got = 1'b1;
        break;
      end
    end
    check("rm_gnt0", int'(got), 1);
    ifc.req0 = 1'b0;
    rcyc = cyc;
    repeat (7) @(negedge clk);
    check("rm_wait_busy", int'(ifc.busy), 1);
    check("rm_wait_noload", int'(ifc.div_load), 0);
    check("rm_wait_cycle", cyc - rcyc, 7);
    res = 1'b0;
    #1;
    check_zero("rst_mid");
    repeat (2) @(negedge clk);
    res  = 1'b1;
    nrsp = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (ifc.rsp_valid) nrsp++;
    end
    check("rm_no_rsp", nrsp, 0);
    run_job("rm_reissue", 1'b0, 5'd29, 5'd3, 5'd9, 5'd2, 1'b0, 10, 5);
    repeat (4) @(negedge clk);
    check("hold_div_a", int'(ifc.div_a), 29);
    check("hold_div_b", int'(ifc.div_b), 3);
    check("hold_rsp_q", int'(ifc.rsp_q), 9);

    check("no_gnt_overlap", ovl_gnt, 0);
    check("no_rsp_load_overlap", ovl_rsp, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/div_arbiter.md
Name: div_arbiter

Overview:
- Round-robin scheduler that shares one div_new 5-bit divider instance between two requesters.
- Captures a request's operands and drives the divider's load/A/B for a fixed load window.
- Waits a fixed compute latency, then samples quotient/reminder/error and returns them on a shared response bus tagged with the requester ID.
- Sits between the ALU issue logic (two issue slots) and the divider datapath.

Parameters:
- W, 5, operand/result width; must match the divider.
- LOAD_CYC, 5, cycles div_load is held high with operands stable (range 1..15).
- DIV_LAT, 5, cycles after div_load falls before divider outputs are sampled (range 1..15).

Ports:
- clk  in  1  system clock, rising edge
- res  in  1  asynchronous active-low reset
- req0  in  1  requester 0 request; held with a0/b0 stable until gnt0
- a0  in  W  requester 0 dividend
- b0  in  W  requester 0 divisor
- gnt0  out  1  one-cycle pulse: requester 0 operands captured
- req1  in  1  requester 1 request
- a1  in  W  requester 1 dividend
- b1  in  W  requester 1 divisor
- gnt1  out  1  one-cycle pulse: requester 1 operands captured
- div_load  out  1  to divider load
- div_a  out  W  to divider A
- div_b  out  W  to divider B
- div_q  in  W  from divider quotient
- div_r  in  W  from divider reminder
- div_err  in  1  from divider error
- rsp_valid  out  1  one-cycle result pulse
- rsp_id  out  1  requester served (0/1)
- rsp_q  out  W  quotient
- rsp_r  out  W  remainder
- rsp_err  out  1  error flag
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (res=0, asynchronous): state=IDLE; all outputs 0; last_id=1, so requester 0 wins first; counters 0.
- Reset mid-operation aborts the job. No response is ever issued for it, and div_load drops immediately.
- FSM states: IDLE, LOAD, WAIT, RESP.
- IDLE, no request pending: stay in IDLE.
- IDLE, one or both requests pending, at the next edge:
  - Select the winner.
  - Pulse gnt of the winner.
  - Latch its a/b into div_a/div_b.
  - Record rsp_id and set last_id = winner.
  - Set div_load=1 and enter LOAD.
- Arbitration: if only one req is high, it wins. If both are high, the requester != last_id wins (strict alternation under contention).
- LOAD: div_load=1 for exactly LOAD_CYC cycles; div_a/div_b held constant. Then div_load=0 and enter WAIT.
- WAIT: DIV_LAT cycles. On the last WAIT edge, register div_q/div_r/div_err into rsp_q/rsp_r/rsp_err, set rsp_valid=1 and enter RESP.
- RESP: rsp_valid high for exactly 1 cycle, then IDLE with rsp_valid=0.
  - rsp_q/rsp_r/rsp_err/rsp_id hold until the next response.
  - No backpressure: consumers must accept on the pulse.
- Latency: gnt pulse to rsp_valid = LOAD_CYC+DIV_LAT cycles (10 at defaults). Next grant is no earlier than 1 cycle after rsp_valid.
- A req deasserted before its grant is simply not served (no error).
- req arriving while busy waits in IDLE. A req held continuously is served again only after the other requester, if the other is requesting.
- gnt0 and gnt1 are never high together. rsp_valid never coincides with div_load.
- div_a/div_b stay at the last operands after completion (no glitching to 0).

Optional Feature:
- Macro: DIV_ZERO_BYPASS_EN.
- Defined: at grant, if the winner's b==0, skip LOAD/WAIT.
  - Next cycle: rsp_valid=1, rsp_err=1, rsp_q=0, rsp_r=0, correct rsp_id.
  - div_load is never asserted for that job.
  - Latency gnt to rsp_valid = 1 cycle.
- Not defined: b==0 goes through the divider like any job; rsp_err/rsp_q/rsp_r are whatever the divider reports.

Test Plan:
- Single request: req0, a0=29, b0=14 -> gnt0 once; div_load high 5 cycles with div_a=29, div_b=14; rsp_valid 10 cycles after gnt0 with rsp_id=0, rsp_q=2, rsp_r=1, rsp_err=0.
- Contention after reset: req0 (10/26) and req1 (21/13) raised in the same cycle -> requester 0 served first (q=0, r=10), then requester 1 (q=1, r=8); gnt1 follows one cycle after the first rsp_valid.
- Alternation: both requesters held high for 4 jobs -> rsp_id sequence 0,1,0,1; no overlapping gnt pulses.
- Divide by zero: req1, a1=21, b1=0 -> with DIV_ZERO_BYPASS_EN, rsp_valid 1 cycle after gnt1 with rsp_err=1, q=r=0 and no div_load; without it, full 10-cycle latency and rsp_err equals div_err.
- Reset mid-op: req0 (29/3) granted, res pulled low in cycle 3 of WAIT -> all outputs 0 asynchronously, no rsp_valid; after release, a re-issued request returns q=9, r=2.
- Withdrawn request: req1 pulsed for one cycle while busy, then dropped -> no gnt1 and no response for ID 1.
